// File: rtl/clock_pkg.sv
// clock_pkg: definitions shared by the timekeeping core.
//   state_e    : FSM state; the encoding is exactly what appears on set_field.
//   TIME_W     : width of every time field.
//   MAX_HOUR   : last hour value before wrapping to 0.
//   MAX_MINSEC : last minute/second value before wrapping to 0.
package clock_pkg;

  localparam int TIME_W = 6;

  localparam logic [TIME_W-1:0] MAX_HOUR   = 6'd23;
  localparam logic [TIME_W-1:0] MAX_MINSEC = 6'd59;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_e;

endpackage

// File: rtl/mod_counter.sv
// mod_counter: wrapping counter 0..MAX.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : advance by one this cycle
//   value    : registered count, never above MAX
//   wrap     : combinational, high when inc is set and value is at MAX
//              (the value returns to 0 at the coming edge)
module mod_counter #(
  parameter int           W   = 6,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         wrap
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;
  logic         at_max;

  // Compare against MAX before incrementing so no out-of-range value exists.
  assign at_max = (value_q == MAX);
  assign wrap   = inc && at_max;

  always_comb begin
    value_d = value_q;
    if (inc) begin
      value_d = at_max ? '0 : value_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/time_counter.sv
// time_counter: timekeeping core of the digital clock.
// A prescaler divides clk to a 1 Hz tick. In RUN the tick advances a 24-hour
// hh:mm:ss count. key_mode cycles RUN->SET_H->SET_M->SET_S->RUN, and in a
// SET state key_inc bumps only the selected field, without carry.
//   clk, rst   : system clock, asynchronous active-high reset
//   key_mode   : one-cycle debounced pulse, advance the mode
//   key_inc    : one-cycle debounced pulse, increment the selected field
//   hours      : 0..23 (binary)
//   minutes    : 0..59 (binary)
//   seconds    : 0..59 (binary)
//   set_field  : FSM state (0=RUN, 1=SET_H, 2=SET_M, 3=SET_S)
//   blink      : blanking hint for the selected field
//   tick_1hz   : high in the cycle the prescaler is at CLK_FREQ-1
//   hour_pulse : high in the cycle a new xx:00:00 first shows
// Key inputs are plain pulses with no handshake. A pulse is seen at a single
// edge, and its effect shows in the cycle after that edge. Every output is a
// register.
module time_counter
  import clock_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_mode,
  input  logic              key_inc,
  output logic [TIME_W-1:0] hours,
  output logic [TIME_W-1:0] minutes,
  output logic [TIME_W-1:0] seconds,
  output logic [1:0]        set_field,
  output logic              blink,
  output logic              tick_1hz,
  output logic              hour_pulse
);

  localparam int PW = $clog2(CLK_FREQ);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_FREQ - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_FREQ / 2);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          blink_q, blink_d;
  logic          hour_pulse_q, hour_pulse_d;

  logic tick_now;
  logic run_tick;
  logic key_inc_eff;
  logic sec_inc, min_inc, hr_inc;
  logic sec_wrap, min_wrap, hr_wrap_unused;

  // FSM next state. key_mode has priority over key_inc everywhere.
  always_comb begin
    state_d = state_q;
    if (key_mode) begin
      case (state_q)
        RUN:     state_d = SET_H;
        SET_H:   state_d = SET_M;
        SET_M:   state_d = SET_S;
        default: state_d = RUN;
      endcase
    end
  end

  // Prescaler: free-running, but restarted when leaving SET_S. That way the
  // first RUN second is a full second long.
  always_comb begin
    tick_now = (presc_q == PRESC_MAX);
    presc_d  = tick_now ? '0 : presc_q + PW'(1);
    if (key_mode && (state_q == SET_S)) begin
      presc_d = '0;
    end
  end

  // Increment sources per field. The carry chain is used only in RUN.
  // A key_inc that arrives together with key_mode is dropped.
  always_comb begin
    run_tick    = (state_q == RUN) && tick_now;
    key_inc_eff = key_inc && !key_mode;
    sec_inc     = run_tick || ((state_q == SET_S) && key_inc_eff);
    min_inc     = (run_tick && sec_wrap) || ((state_q == SET_M) && key_inc_eff);
    hr_inc      = (run_tick && sec_wrap && min_wrap) ||
                  ((state_q == SET_H) && key_inc_eff);
  end

  // Registered outputs, computed from next-state values so that they line up
  // with the state and time that they describe.
  always_comb begin
    tick_d       = (presc_d == PRESC_MAX);
    blink_d      = (state_d != RUN) && (presc_d < PRESC_HALF);
    hour_pulse_d = run_tick && sec_wrap && min_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      presc_q      <= '0;
      tick_q       <= 1'b0;
      blink_q      <= 1'b0;
      hour_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      tick_q       <= tick_d;
      blink_q      <= blink_d;
      hour_pulse_q <= hour_pulse_d;
    end
  end

  mod_counter #(.W(TIME_W), .MAX(MAX_MINSEC)) u_sec (
    .clk   (clk),
    .rst   (rst),
    .inc   (sec_inc),
    .value (seconds),
    .wrap  (sec_wrap)
  );

  mod_counter #(.W(TIME_W), .MAX(MAX_MINSEC)) u_min (
    .clk   (clk),
    .rst   (rst),
    .inc   (min_inc),
    .value (minutes),
    .wrap  (min_wrap)
  );

  // The day rollover has no consumer downstream.
  mod_counter #(.W(TIME_W), .MAX(MAX_HOUR)) u_hr (
    .clk   (clk),
    .rst   (rst),
    .inc   (hr_inc),
    .value (hours),
    .wrap  (hr_wrap_unused)
  );

  assign set_field  = state_q;
  assign blink      = blink_q;
  assign tick_1hz   = tick_q;
  assign hour_pulse = hour_pulse_q;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter at CLK_FREQ=4. Expected values are pushed
// to exp_q next to the stimulus and popped when the DUT output is sampled
// (#1 after the rising edge). Time is compared as hh*10000+mm*100+ss.
module tb_time_counter;

  localparam int CF = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_mode;
  logic       key_inc;
  logic [5:0] hours, minutes, seconds;
  logic [1:0] set_field;
  logic       blink, tick_1hz, hour_pulse;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // Reference prescaler phase and FSM state for the tick/blink expectations.
  int m_presc;
  int m_state;

  time_counter #(.CLK_FREQ(CF)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_mode   (key_mode),
    .key_inc    (key_inc),
    .hours      (hours),
    .minutes    (minutes),
    .seconds    (seconds),
    .set_field  (set_field),
    .blink      (blink),
    .tick_1hz   (tick_1hz),
    .hour_pulse (hour_pulse)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  function automatic logic [31:0] tw();
    return 32'(hours) * 32'd10000 + 32'(minutes) * 32'd100 + 32'(seconds);
  endfunction

  function automatic logic [31:0] flags();
    return {27'd0, set_field, blink, tick_1hz, hour_pulse};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: got=%0d expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $display("FAIL %s: got=%0d expected=%0d", tag, obs, e);
        $error("%s got=%0d expected=%0d", tag, obs, e);
      end
    end
  endtask

  task automatic check_phase(input string tag);
    exp_q.push_back(32'(m_state));
    check({tag, "_state"}, 32'(set_field));
    exp_q.push_back((m_presc == CF - 1) ? 32'd1 : 32'd0);
    check({tag, "_tick"}, 32'(tick_1hz));
    exp_q.push_back((m_state != 0 && m_presc < CF / 2) ? 32'd1 : 32'd0);
    check({tag, "_blink"}, 32'(blink));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic m, input logic i);
    key_mode = m;
    key_inc  = i;
    @(posedge clk);
    #1;
    key_mode = 1'b0;
    key_inc  = 1'b0;
    if (m && m_state == 3) m_presc = 0;
    else                   m_presc = (m_presc + 1) % CF;
    if (m) m_state = (m_state + 1) % 4;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst      = 1'b1;
    key_mode = 1'b0;
    key_inc  = 1'b0;
    m_presc  = 0;
    m_state  = 0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(32'd0); check("reset_time", tw());
    exp_q.push_back(32'd0); check("reset_flags", flags());
    rst = 1'b0;

    // Count a little, then reset asynchronously in mid-cycle.
    repeat (10) step(1'b0, 1'b0);
    exp_q.push_back(32'd2); check("pre_reset_time", tw());
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.push_back(32'd0); check("async_reset_time", tw());
    exp_q.push_back(32'd0); check("async_reset_flags", flags());
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_presc = 0;
    m_state = 0;

    // Free run for 240 cycles.
    for (int k = 1; k <= 240; k++) begin
      step(1'b0, 1'b0);
      exp_q.push_back(32'd0); check("free_hour_pulse", 32'(hour_pulse));
      check_phase("free");
      if (k == 120) begin
        exp_q.push_back(32'd30); check("free_half_time", tw());
      end
    end
    exp_q.push_back(32'd100); check("free_run_time", tw());

    // Enter SET_H. Increment hours 25 times, so they wrap through 23.
    step(1'b1, 1'b0);
    check_phase("enter_set_h");
    exp_q.push_back(32'd100); check("set_h_entry_time", tw());
    repeat (25) step(1'b0, 1'b1);
    exp_q.push_back(32'd10100); check("hours_25_incs", tw());

    // Frozen time with the blink pattern in SET_H.
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b0);
      check_phase("frozen");
    end
    exp_q.push_back(32'd10100); check("frozen_time", tw());

    // Build 23:59:59 using the keys.
    repeat (22) step(1'b0, 1'b1);
    exp_q.push_back(32'd230100); check("hours_23", tw());
    step(1'b1, 1'b0);
    repeat (58) step(1'b0, 1'b1);
    exp_q.push_back(32'd235900); check("min_59", tw());

    // Both keys together in SET_M: the mode change wins.
    step(1'b1, 1'b1);
    exp_q.push_back(32'd235900); check("simul_keys_time", tw());
    exp_q.push_back(32'd3);      check("simul_keys_state", 32'(set_field));
    repeat (59) step(1'b0, 1'b1);
    exp_q.push_back(32'd235959); check("sec_59", tw());
    check_phase("set_s");

    // Back to RUN. The prescaler restarts, and the rollover comes 4 cycles later.
    step(1'b1, 1'b0);
    check_phase("exit_set");
    exp_q.push_back(32'd235959); check("exit_set_time", tw());
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b0);
      check_phase("pre_roll");
      exp_q.push_back(32'd0); check("pre_roll_hour_pulse", 32'(hour_pulse));
    end
    exp_q.push_back(32'd235959); check("pre_roll_time", tw());
    step(1'b0, 1'b0);
    exp_q.push_back(32'd0); check("rollover_time", tw());
    exp_q.push_back(32'd1); check("rollover_hour_pulse", 32'(hour_pulse));
    step(1'b0, 1'b0);
    exp_q.push_back(32'd0); check("post_roll_hour_pulse", 32'(hour_pulse));
    exp_q.push_back(32'd0); check("post_roll_time", tw());

    // key_inc is ignored in RUN.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    exp_q.push_back(32'd0); check("run_inc_ignored", tw());
    check_phase("run_inc");

    // A tick together with key_mode: the time advances and SET_H is entered.
    step(1'b1, 1'b0);
    exp_q.push_back(32'd1); check("tick_with_mode_time", tw());
    check_phase("tick_with_mode");
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0);
      check_phase("blink_set_h");
    end

    // Reset in the middle of set mode.
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.push_back(32'd0); check("set_reset_time", tw());
    exp_q.push_back(32'd0); check("set_reset_flags", flags());
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_presc = 0;
    m_state = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0);
      check_phase("after_reset");
    end
    exp_q.push_back(32'd1); check("after_reset_time", tw());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
